// File: rtl/word_serial_tx_pkg.sv
// Shared definitions for the word-serial transmitter and its matching receiver:
// state encodings, default geometry and the idle level of the serial line.
package word_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int   DEF_DATA_W  = 16;
    localparam int   DEF_CLK_DIV = 4;
    localparam int   BIT_CNT_W   = 5;
    localparam logic LINE_IDLE   = 1'b1;

endpackage

// File: rtl/word_serial_tx_bit_timer.sv
// Modulo-CLK_DIV bit-period counter; tick marks the last cycle of each bit period.
// Shared with the matching receiver.
module bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clear || tick) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/word_serial_tx.sv
// Parallel-in serial-out transmitter: start bit, DATA_W data bits LSB-first, stop bit.
// Handshake: a word is taken on any rising edge where ready=1 and load=1; load is ignored otherwise.
module word_serial_tx
    import word_serial_tx_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              busy,
    output logic              tx_out,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    tx_state_e             state_q, state_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  timer_clr;
    logic                  tick;

    bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clr),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        timer_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Timer held at zero so the start bit gets a full period.
                timer_clr = 1'b1;
                tx_d      = LINE_IDLE;
                if (load) begin
                    shift_d = data_in;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = LINE_IDLE;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    tx_d    = LINE_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= LINE_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign busy        = ~ready;
    assign tx_out      = tx_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_word_serial_tx.sv
// Directed and random frames for word_serial_tx, checked cycle by cycle against
// a frame-level reference built from the start/data/stop bit rules.
module tb_word_serial_tx;

  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = (DATA_W + 2) * CLK_DIV;

  logic              clock;
  logic              reset_n;
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              busy;
  logic              tx_out;
  logic              done;
  logic [1:0]        dbg_state;

  int n_checks;
  int n_fail;

  word_serial_tx #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .load        (load),
    .ready       (ready),
    .busy        (busy),
    .tx_out      (tx_out),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bit k of the frame on the line (0 = start, 1..DATA_W = data LSB first, last = stop).
  function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_W) return w[idx-1];
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_tx"},    {31'd0, tx_out}, 32'd1);
    check({tag, "_ready"}, {31'd0, ready},  32'd1);
    check({tag, "_busy"},  {31'd0, busy},   32'd0);
    check({tag, "_done"},  {31'd0, done},   32'd0);
  endtask

  // Caller has set data_in/load before the accepting edge and is at a negedge.
  // Returns at the negedge of the done cycle. Samples after k edges past acceptance.
  task automatic run_frame(input logic [DATA_W-1:0] word, input bit hold_load,
                           input int abort_at, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clock);
      if (k == 0 && !hold_load) load = 1'b0;
      if (k == 20) data_in = 16'h1234;
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_tx",    {31'd0, tx_out}, 32'd1);
        check("abort_ready", {31'd0, ready},  32'd1);
        check("abort_busy",  {31'd0, busy},   32'd0);
        check("abort_done",  {31'd0, done},   32'd0);
        aborted = 1'b1;
        return;
      end
      if (k < FRAME) begin
        check($sformatf("tx_k%0d", k), {31'd0, tx_out}, {31'd0, frame_bit(word, k / CLK_DIV)});
        check($sformatf("busy_k%0d", k), {31'd0, busy}, 32'd1);
        check($sformatf("ready_k%0d", k), {31'd0, ready}, 32'd0);
        check($sformatf("done_k%0d", k), {31'd0, done}, 32'd0);
      end else begin
        check("end_done",  {31'd0, done},  32'd1);
        check("end_ready", {31'd0, ready}, 32'd1);
        check("end_busy",  {31'd0, busy},  32'd0);
        check("end_tx",    {31'd0, tx_out}, 32'd1);
      end
    end
  endtask

  initial begin
    bit ab;
    logic [DATA_W-1:0] w;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    load     = 1'b0;
    data_in  = '0;

    // reset for 3 cycles
    repeat (3) @(negedge clock);
    check_idle("in_reset");
    check("in_reset_state", {30'd0, dbg_state}, 32'd0);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check_idle("post_reset");
    end

    // 16'h001B, single-cycle load
    data_in = 16'h001B; load = 1'b1;
    run_frame(16'h001B, 1'b0, -1, ab);
    @(negedge clock);
    check_idle("after_001b");
    check("after_001b_state", {30'd0, dbg_state}, 32'd0);

    // 16'hFFFF
    data_in = 16'hFFFF; load = 1'b1;
    run_frame(16'hFFFF, 1'b0, -1, ab);
    @(negedge clock);
    check_idle("after_ffff");

    // load held high throughout, data_in changes mid-frame
    data_in = 16'hA5C3; load = 1'b1;
    run_frame(16'hA5C3, 1'b1, -1, ab);
    // done cycle: chain the next frame with no idle gap
    data_in = 16'h8001; load = 1'b1;
    run_frame(16'h8001, 1'b0, -1, ab);
    @(negedge clock);
    check_idle("after_8001");

    // random frames with random idle gaps, some chained
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clock);
        check_idle("rand_gap");
      end
      w = DATA_W'($urandom);
      data_in = w; load = 1'b1;
      run_frame(w, 1'b0, -1, ab);
    end
    @(negedge clock);
    check_idle("after_rand");

    // reset mid-frame at cycle 30
    data_in = 16'h5A5A; load = 1'b1;
    run_frame(16'h5A5A, 1'b0, 30, ab);
    check("abort_taken", {31'd0, ab}, 32'd1);
    repeat (2) begin
      @(negedge clock);
      check_idle("abort_hold");
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check_idle("abort_release");
    end
    w = DATA_W'($urandom);
    data_in = w; load = 1'b1;
    run_frame(w, 1'b0, -1, ab);
    @(negedge clock);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serial_tx.md
Name: word_serial_tx

Overview:
- Parallel-in, serial-out transmitter that reads the 16-bit word held in a data register and sends it on a single wire.
- Acts as the consumer end of the data-register interface: takes data_out from the register bank and frames it as start bit, 16 data bits LSB-first, stop bit.
- Serves as the processor's debug/output port; the receiver end is a separate block.

Parameters:
- DATA_W, 16, width of the transmitted word.
- CLK_DIV, 4, clock cycles per serial bit period; legal range is 2..255.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  word to send; sampled only when a load is accepted.
- load  input  1  request to send data_in; level-sensitive, honoured only while ready=1.
- ready  output  1  high when idle and able to accept load.
- busy  output  1  high while a frame is in progress; always the inverse of ready.
- tx_out  output  1  serial line; idles high. Driven from a register, so it has no glitches.
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, tx_out=1, done=0, ready=1, busy=0.
  - Shift register, bit-period counter and bit counter are cleared.
- Reset asserted mid-frame aborts the frame immediately: tx_out returns to 1 without waiting for a clock edge. No done pulse is produced.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - ready=1, tx_out=1.
  - On an edge with load=1: capture data_in into the shift register, go to START, drive tx_out=0, clear the bit-period counter.
- START:
  - tx_out=0 for exactly CLK_DIV cycles.
  - At the end of the bit period: go to DATA, drive tx_out=shift[0], bit counter=0.
- DATA:
  - Each bit is held for CLK_DIV cycles.
  - At the end of each bit period: shift right and increment the bit counter.
  - After bit DATA_W-1 completes: go to STOP, drive tx_out=1.
- STOP:
  - tx_out=1 for CLK_DIV cycles.
  - At the end of the bit period: go to IDLE with done=1 for exactly that one cycle.
- Frame timing:
  - Frame length is exactly (DATA_W+2)*CLK_DIV cycles, measured from the accepting edge to the edge that returns to IDLE.
  - The first tx_out=0 is visible in the cycle after the accepting edge.
- Bit-period counter:
  - Counts 0..CLK_DIV-1 and wraps to 0 at each bit boundary.
  - Bit counter is 5 bits wide; it is compared against DATA_W-1 and never wraps.
- load while busy: ignored. data_in changes during a frame have no effect on the word being sent.
- Back-to-back frames:
  - In the done cycle the block is in IDLE with ready=1.
  - If load=1 in that cycle, the next frame starts at the following edge with no extra idle bit.
- done and ready are registered/decoded from state only; neither depends combinationally on load.

Decomposition:
- Shared include file (tx_defs.vh) holds:
  - the 2-bit state encodings: IDLE=0, START=1, DATA=2, STOP=3;
  - default DATA_W and CLK_DIV;
  - the line idle level constant (1).
- One sub-module, bit_timer:
  - CLK_DIV-modulo counter with a clear input and a tick output.
  - tick asserts in the last cycle of each bit period.
  - Reused by the matching receiver.

Test Plan (CLK_DIV=4, DATA_W=16):
- Reset: hold reset_n=0 for 3 cycles, then release -> tx_out=1, ready=1, busy=0, done=0. Hold these values until a load arrives.
- Send 16'h001B with a 1-cycle load -> tx_out sequence, each value held 4 cycles:
  - start bit 0;
  - data bits 1,1,0,1,1, then eleven 0s;
  - stop bit 1.
  - done pulses at cycle 72 after acceptance; busy is high for exactly 72 cycles.
- Send 16'hFFFF -> tx_out=0 for 4 cycles, then 1 for 68 cycles. done pulses once and ready returns to 1.
- load held high while busy, with data_in changed to 16'h1234 at cycle 20 -> the frame still carries the originally captured word. No second frame starts until done.
- Back-to-back: load=1 in the done cycle with data_in=16'h8001 -> the next start bit begins with no idle gap. Second frame's data bits are 1, then fourteen 0s, then 1.
- Reset mid-frame: pull reset_n low at cycle 30 of a frame -> tx_out=1 immediately (asynchronous), ready=1, no done pulse. A fresh load after release sends a complete frame.
